aes_encrypt_iter: RTL and testbench

Iterative AES block-encryption core, generalising the single combinational round into a multi-cycle engine with a key-length parameter. It executes one full AES round per clock using one instance each of Sub_bytes, Shift_rows, Mix_columns and Add_RoundKey. Round keys are expanded on the fly, and blocks move through valid/ready handshakes on both the input and output sides. It sits between the host-side block buffer and the ciphertext output stage.

---
 rtl/aes_encrypt_iter.sv | 213 +++++++++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one full round per clock, on-the-fly key expansion,
// valid/ready handshakes on both sides. KEY_BITS selects AES-128 or AES-256.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 by an addition chain; 0 maps to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gfMul(gfMul(x, x), x);
    x7   = gfMul(gfMul(x3, x3), x);
    x15  = gfMul(gfMul(x7, x7), x);
    x31  = gfMul(gfMul(x15, x15), x);
    x63  = gfMul(gfMul(x31, x31), x);
    x127 = gfMul(gfMul(x63, x63), x);
    return gfMul(x127, x127);
  endfunction

  logic [7:0] inv;
  assign inv = gfInv(a);
  assign s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module Sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar g = 0; g < 16; g++) begin : gLane
    aes_sbox uSbox (.a(din[8*g +: 8]), .s(dout[8*g +: 8]));
  end
endmodule

module Shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  // State byte i = r + 4c lives at bits [127-8i -: 8]; row r rotates left by r.
  for (genvar r = 0; r < 4; r++) begin : gRow
    for (genvar c = 0; c < 4; c++) begin : gCol
      assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

module aes_mix_col (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = din;
  assign dout = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module Mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : gLane
    aes_mix_col uCol (.din(din[127-32*c -: 32]), .dout(dout[127-32*c -: 32]));
  end
endmodule

module Add_RoundKey (
  input  logic [127:0] din,
  input  logic [127:0] key,
  output logic [127:0] dout
);
  assign dout = din ^ key;
endmodule

module aes_encrypt_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);
  localparam int NR = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] LAST_RND = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : gBadKeyBits
    $error("aes_encrypt_iter: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] stateQ, keyPrev, keyPrev2;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         outValid;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Key schedule: keyPrev is round key i-1; for AES-256 keyPrev2 is round key i-2.
  logic         useRot;
  logic [31:0]  lastW, subIn, subOut, gWord, n0, n1, n2, n3;
  logic [127:0] baseKey, nextKey, roundKey;

  always_comb begin
    lastW   = keyPrev[31:0];
    useRot  = 1'b1;
    baseKey = keyPrev;
    if (KEY_BITS == 256) begin
      useRot  = ~rnd[0];
      baseKey = keyPrev2;
    end
    subIn = useRot ? {lastW[23:0], lastW[31:24]} : lastW;
    gWord = subOut ^ (useRot ? {rcon, 24'h0} : 32'h0);
    n0 = baseKey[127:96] ^ gWord;
    n1 = baseKey[95:64]  ^ n0;
    n2 = baseKey[63:32]  ^ n1;
    n3 = baseKey[31:0]   ^ n2;
    nextKey  = {n0, n1, n2, n3};
    roundKey = nextKey;
    // AES-256 round key 1 is the low half of the cipher key itself.
    if (KEY_BITS == 256 && rnd == 4'd1) roundKey = keyPrev;
  end

  for (genvar g = 0; g < 4; g++) begin : gKeySbox
    aes_sbox uSbox (.a(subIn[8*g +: 8]), .s(subOut[8*g +: 8]));
  end

  logic [127:0] sbOut, srOut, mcOut, arkIn, roundOut;
  logic         lastRnd;

  assign lastRnd = (rnd == LAST_RND);
  assign arkIn   = lastRnd ? srOut : mcOut;

  Sub_bytes    uSub (.din(stateQ), .dout(sbOut));
  Shift_rows   uShr (.din(sbOut),  .dout(srOut));
  Mix_columns  uMix (.din(srOut),  .dout(mcOut));
  Add_RoundKey uArk (.din(arkIn),  .key(roundKey), .dout(roundOut));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      stateQ   <= '0;
      keyPrev  <= '0;
      keyPrev2 <= '0;
      rnd      <= '0;
      rcon     <= 8'h01;
      outValid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          stateQ   <= in_data ^ in_key[KEY_BITS-1 -: 128];
          keyPrev  <= in_key[127:0];
          keyPrev2 <= in_key[KEY_BITS-1 -: 128];
          rcon     <= 8'h01;
          rnd      <= 4'd1;
          fsm      <= ROUND;
        end
        ROUND: begin
          stateQ <= roundOut;
          rnd    <= rnd + 4'd1;
          if (KEY_BITS == 128) begin
            keyPrev <= nextKey;
            rcon    <= xtime(rcon);
          end else if (rnd != 4'd1) begin
            keyPrev2 <= keyPrev;
            keyPrev  <= nextKey;
            if (!rnd[0]) rcon <= xtime(rcon);
          end
          if (lastRnd) begin
            fsm      <= DONE;
            outValid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          fsm      <= IDLE;
          outValid <= 1'b0;
          rnd      <= '0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign busy      = (fsm != IDLE);
  assign out_valid = outValid;
  assign out_data  = stateQ;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors, latency, backpressure,
// back-to-back throughput and mid-block reset, on AES-128 and AES-256 instances.

module tb_aes_encrypt_iter;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] C3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         aInValid = 1'b0, aInReady, aOutValid, aOutReady = 1'b1, aBusy;
  logic [127:0] aInData = '0, aOutData;
  logic [127:0] aInKey = '0;
  logic         bInValid = 1'b0, bInReady, bOutValid, bOutReady = 1'b1, bBusy;
  logic [127:0] bInData = '0, bOutData;
  logic [255:0] bInKey = '0;

  aes_encrypt_iter #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_key(aInKey),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .busy(aBusy)
  );

  aes_encrypt_iter #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_key(bInKey),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .busy(bBusy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int accTimes[$];
  logic accNext = 1'b0;

  // Inputs only change 1ns after a rising edge, so the falling-edge sample predicts acceptance.
  always @(negedge clk) accNext = aInValid && aInReady;
  always @(posedge clk) begin
    cyc++;
    if (accNext && rst_n) accTimes.push_back(cyc);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitOut(input bit selB, output int n);
    n = 0;
    while (!(selB ? bOutValid : aOutValid) && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, base;
    bit ok;

    #2;
    check("rst_in_ready",  128'(aInReady),  128'd1);
    check("rst_out_valid", 128'(aOutValid), 128'd0);
    check("rst_busy",      128'(aBusy),     128'd0);
    check("rst_out_data",  aOutData,        128'd0);
    check("rst_out_data256", bOutData,      128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // App. B with a 20-cycle stall in DONE
    base = accTimes.size();
    aOutReady = 1'b0;
    aInData = B_PT; aInKey = B_KEY; aInValid = 1'b1;
    tick();
    aInValid = 1'b0; aInData = ~B_PT; aInKey = ~B_KEY;
    check("acc_busy",     128'(aBusy),    128'd1);
    check("acc_in_ready", 128'(aInReady), 128'd0);
    waitOut(1'b0, n);
    check("lat128_B", 128'(n), 128'd10);
    check("ct_B", aOutData, B_CT);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      aInValid = i[0];
      aInData = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (aOutData !== B_CT || aInReady !== 1'b0 || aOutValid !== 1'b1) ok = 1'b0;
    end
    aInValid = 1'b0;
    check("stall_stable", 128'(ok), 128'd1);
    check("stall_no_acc", 128'(accTimes.size()), 128'(base + 1));
    aOutReady = 1'b1;
    tick();
    check("release_in_ready",  128'(aInReady),  128'd1);
    check("release_out_valid", 128'(aOutValid), 128'd0);

    // Back-to-back: C.1 then App. B with in_valid held high
    base = accTimes.size();
    aInData = C_PT; aInKey = C1_KEY; aInValid = 1'b1;
    tick();
    aInData = B_PT; aInKey = B_KEY;
    waitOut(1'b0, n);
    check("lat128_C1", 128'(n), 128'd10);
    check("ct_C1", aOutData, C1_CT);
    tick();
    tick();
    aInValid = 1'b0;
    waitOut(1'b0, n);
    check("lat128_B2", 128'(n), 128'd10);
    check("ct_B2", aOutData, B_CT);
    check("b2b_acc_count", 128'(accTimes.size()), 128'(base + 2));
    if (accTimes.size() >= base + 2)
      check("b2b_spacing", 128'(accTimes[base+1] - accTimes[base]), 128'd12);
    tick();

    // Reset while round 5 is executing
    aInData = C_PT; aInKey = C1_KEY; aInValid = 1'b1;
    tick();
    aInValid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(aOutValid), 128'd0);
    check("midrst_in_ready",  128'(aInReady),  128'd1);
    check("midrst_busy",      128'(aBusy),     128'd0);
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (aOutValid !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_output", 128'(ok), 128'd1);
    aInData = C_PT; aInKey = C1_KEY; aInValid = 1'b1;
    tick();
    aInValid = 1'b0;
    waitOut(1'b0, n);
    check("lat128_after_rst", 128'(n), 128'd10);
    check("ct_C1_after_rst", aOutData, C1_CT);
    tick();

    // AES-256, App. C.3
    bInData = C_PT; bInKey = C3_KEY; bInValid = 1'b1;
    tick();
    bInValid = 1'b0; bInData = '0; bInKey = '0;
    check("acc256_busy", 128'(bBusy), 128'd1);
    waitOut(1'b1, n);
    check("lat256_C3", 128'(n), 128'd14);
    check("ct_C3", bOutData, C3_CT);
    tick();
    check("done256_in_ready", 128'(bInReady), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
